// File: rtl/port_sideband_ctrl_pkg.sv
// rtl/port_sideband_ctrl_pkg.sv - register map, bit offsets and module-select FSM encoding
package port_sideband_ctrl_pkg;

  // Word addresses, decoded from amm_address[2:0]
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_EVENT  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_EN = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_MSEL   = 3'd4;
  localparam logic [2:0] ADDR_RESET  = 3'd5;

  // STATUS / EVENT / IRQ_EN share one layout
  localparam int PRS_LSB = 0;
  localparam int LOS_LSB = 8;
  localparam int INT_BIT = 16;

  // CTRL field offsets (txdis sits at bit 0)
  localparam int RS0_LSB = 8;
  localparam int RS1_LSB = 16;

  // MSEL flag bits
  localparam int MSEL_BUSY_BIT = 30;
  localparam int MSEL_REQ_BIT  = 31;

  typedef enum logic [1:0] {
    MSEL_IDLE      = 2'd0,
    MSEL_WAIT_BUSY = 2'd1,
    MSEL_GUARD     = 2'd2,
    MSEL_SEL       = 2'd3
  } msel_state_t;

  // Build a STATUS/EVENT/IRQ_EN word from zero-extended per-port fields
  function automatic logic [31:0] pack_evt(input logic [7:0] prs, input logic [7:0] los,
                                           input logic int_b);
    logic [31:0] w;
    w = '0;
    w[PRS_LSB +: 8] = prs;
    w[LOS_LSB +: 8] = los;
    w[INT_BIT]      = int_b;
    return w;
  endfunction

endpackage

// File: rtl/sideband_debounce.sv
// rtl/sideband_debounce.sv - two-flop synchroniser plus stable-count debouncer with toggle pulse
module sideband_debounce #(
  parameter int   DEB_CYCLES = 65536,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic toggle
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // High in the cycle before dout flips, so event latches line up with the new value
  assign toggle = (sync2 != dout) && (cnt == CNT_LAST);

  // Count consecutive differing cycles; any matching cycle restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RST_VAL;
      cnt  <= '0;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      dout <= sync2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/port_sideband_ctrl.sv
// rtl/port_sideband_ctrl.sv - (Q)SFP sideband controller: registers, module-select FSM, reset timer
module port_sideband_ctrl
  import port_sideband_ctrl_pkg::*;
#(
  parameter int NPORTS       = 5,
  parameter int DEB_CYCLES   = 65536,
  parameter int GUARD_CYCLES = 64,
  parameter int RST_CYCLES   = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [9:0]        amm_address,
  input  logic              amm_write,
  input  logic [31:0]       amm_writedata,
  input  logic              amm_read,
  output logic [31:0]       amm_readdata,
  output logic              amm_waitrequest,
  input  logic [NPORTS-1:0] port_prsnt_n,
  input  logic [NPORTS-1:0] port_rxlos,
  input  logic              port_int_n,
  output logic [NPORTS-1:0] port_txdis,
  output logic [NPORTS-1:0] port_rs0,
  output logic [NPORTS-1:0] port_rs1,
  output logic [NPORTS-1:0] port_msel_n,
  output logic              port_rst_n,
  input  logic              i2c_busy,
  output logic              irq
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [3:0] NPORTS_4 = 4'(NPORTS);

  logic [2:0] addr;
  logic       unused_bits;
  assign addr        = amm_address[2:0];
  assign unused_bits = ^{amm_address[9:3], amm_writedata};

  // ---------------- input conditioning ----------------
  logic [NPORTS-1:0] prs_deb, prs_tog, los_deb, los_tog;
  logic              int_deb, int_tog, int_rise;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    sideband_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_prs (
      .clk(sys_clk), .rst(sys_rst), .din(~port_prsnt_n[i]),
      .dout(prs_deb[i]), .toggle(prs_tog[i])
    );
    sideband_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_los (
      .clk(sys_clk), .rst(sys_rst), .din(port_rxlos[i]),
      .dout(los_deb[i]), .toggle(los_tog[i])
    );
  end

  sideband_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_int (
    .clk(sys_clk), .rst(sys_rst), .din(~port_int_n),
    .dout(int_deb), .toggle(int_tog)
  );

  // Toggle while currently low means the line is about to rise
  assign int_rise = int_tog & ~int_deb;

  // ---------------- register file ----------------
  logic              wr_event, wr_irq_en, wr_ctrl, wr_msel, wr_reset;
  logic [NPORTS-1:0] ev_prs, ev_los, en_prs, en_los;
  logic              ev_int, en_int;

  assign wr_event  = amm_write && (addr == ADDR_EVENT);
  assign wr_irq_en = amm_write && (addr == ADDR_IRQ_EN);
  assign wr_ctrl   = amm_write && (addr == ADDR_CTRL);
  assign wr_reset  = amm_write && (addr == ADDR_RESET) && amm_writedata[0];
  // Out-of-range port indices make the whole MSEL write a no-op
  assign wr_msel   = amm_write && (addr == ADDR_MSEL) && ({1'b0, amm_writedata[2:0]} < NPORTS_4);

  // Control/enable registers; sticky events where a new set beats a same-cycle clear
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      port_txdis <= '1;
      port_rs0   <= '0;
      port_rs1   <= '0;
      en_prs     <= '0;
      en_los     <= '0;
      en_int     <= 1'b0;
      ev_prs     <= '0;
      ev_los     <= '0;
      ev_int     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        port_txdis <= amm_writedata[0 +: NPORTS];
        port_rs0   <= amm_writedata[RS0_LSB +: NPORTS];
        port_rs1   <= amm_writedata[RS1_LSB +: NPORTS];
      end
      if (wr_irq_en) begin
        en_prs <= amm_writedata[PRS_LSB +: NPORTS];
        en_los <= amm_writedata[LOS_LSB +: NPORTS];
        en_int <= amm_writedata[INT_BIT];
      end
      ev_prs <= (ev_prs & ~(wr_event ? amm_writedata[PRS_LSB +: NPORTS] : '0)) | prs_tog;
      ev_los <= (ev_los & ~(wr_event ? amm_writedata[LOS_LSB +: NPORTS] : '0)) | los_tog;
      ev_int <= (ev_int & ~(wr_event & amm_writedata[INT_BIT])) | int_rise;
      irq    <= |{ev_prs & en_prs, ev_los & en_los, ev_int & en_int};
    end
  end

  // ---------------- module-select FSM ----------------
  msel_state_t state, state_nxt;
  logic [2:0]  cur_idx, cur_idx_nxt, pend_idx, pend_idx_nxt, eff_idx;
  logic        pend_req, pend_req_nxt, eff_req;
  logic [GW-1:0] guard_cnt, guard_cnt_nxt;
  logic        msel_busy, msel_granted;

  // A write while a change is pending replaces the pending target
  assign eff_idx = wr_msel ? amm_writedata[2:0] : pend_idx;
  assign eff_req = wr_msel ? amm_writedata[MSEL_REQ_BIT] : pend_req;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= MSEL_IDLE;
      cur_idx   <= '0;
      pend_idx  <= '0;
      pend_req  <= 1'b0;
      guard_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cur_idx   <= cur_idx_nxt;
      pend_idx  <= pend_idx_nxt;
      pend_req  <= pend_req_nxt;
      guard_cnt <= guard_cnt_nxt;
    end
  end

  // Next-state: drain I2C, hold all deselected for the guard gap, then select
  always_comb begin
    state_nxt     = state;
    cur_idx_nxt   = cur_idx;
    pend_idx_nxt  = pend_idx;
    pend_req_nxt  = pend_req;
    guard_cnt_nxt = guard_cnt;
    case (state)
      MSEL_IDLE: begin
        if (wr_msel && amm_writedata[MSEL_REQ_BIT]) begin
          state_nxt    = MSEL_WAIT_BUSY;
          pend_idx_nxt = amm_writedata[2:0];
          pend_req_nxt = 1'b1;
        end
      end
      MSEL_WAIT_BUSY: begin
        pend_idx_nxt = eff_idx;
        pend_req_nxt = eff_req;
        if (!i2c_busy) begin
          guard_cnt_nxt = '0;
          state_nxt     = eff_req ? MSEL_GUARD : MSEL_IDLE;
        end
      end
      MSEL_GUARD: begin
        pend_idx_nxt = eff_idx;
        pend_req_nxt = eff_req;
        if (guard_cnt == GUARD_LAST) begin
          if (eff_req) begin
            state_nxt   = MSEL_SEL;
            cur_idx_nxt = eff_idx;
          end else begin
            state_nxt = MSEL_IDLE;
          end
        end else begin
          guard_cnt_nxt = guard_cnt + GW'(1);
        end
      end
      default: begin
        if (wr_msel) begin
          state_nxt    = MSEL_WAIT_BUSY;
          pend_idx_nxt = amm_writedata[2:0];
          pend_req_nxt = amm_writedata[MSEL_REQ_BIT];
        end
      end
    endcase
  end

  // Outputs: exactly one select low only while granted
  always_comb begin
    msel_busy    = (state == MSEL_WAIT_BUSY) || (state == MSEL_GUARD);
    msel_granted = (state == MSEL_SEL);
    port_msel_n  = '1;
    for (int i = 0; i < NPORTS; i++) begin
      port_msel_n[i] = !(msel_granted && (cur_idx == 3'(i)));
    end
  end

  // ---------------- module reset timer ----------------
  logic          rst_act;
  logic [RW-1:0] rst_cnt;

  // Retrigger restarts the count from zero
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rst_act <= 1'b0;
      rst_cnt <= '0;
    end else if (wr_reset) begin
      rst_act <= 1'b1;
      rst_cnt <= '0;
    end else if (rst_act) begin
      if (rst_cnt == RST_LAST) rst_act <= 1'b0;
      else                     rst_cnt <= rst_cnt + RW'(1);
    end
  end

  assign port_rst_n = ~rst_act;

  // ---------------- read path ----------------
  logic [31:0] rd_mux;
  logic        rd_phase;

  // Read data selection
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_STATUS: rd_mux = pack_evt(8'(prs_deb), 8'(los_deb), int_deb);
      ADDR_EVENT:  rd_mux = pack_evt(8'(ev_prs), 8'(ev_los), ev_int);
      ADDR_IRQ_EN: rd_mux = pack_evt(8'(en_prs), 8'(en_los), en_int);
      ADDR_CTRL: begin
        rd_mux[0 +: 8]       = 8'(port_txdis);
        rd_mux[RS0_LSB +: 8] = 8'(port_rs0);
        rd_mux[RS1_LSB +: 8] = 8'(port_rs1);
      end
      ADDR_MSEL: begin
        rd_mux[2:0]           = cur_idx;
        rd_mux[MSEL_BUSY_BIT] = msel_busy;
        rd_mux[MSEL_REQ_BIT]  = msel_granted;
      end
      ADDR_RESET: rd_mux[0] = rst_act;
      default:    rd_mux = '0;
    endcase
  end

  // One wait cycle per read; data captured at the end of the wait cycle and held
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_phase     <= 1'b0;
      amm_readdata <= '0;
    end else if (amm_read && !rd_phase) begin
      rd_phase     <= 1'b1;
      amm_readdata <= rd_mux;
    end else begin
      rd_phase <= 1'b0;
    end
  end

  assign amm_waitrequest = amm_read && !rd_phase;

endmodule

// File: tb/tb_port_sideband_ctrl.sv
// tb/tb_port_sideband_ctrl.sv - self-checking bench for port_sideband_ctrl
module tb_port_sideband_ctrl;

  localparam int NP = 5;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [9:0]    amm_address;
  logic          amm_write;
  logic [31:0]   amm_writedata;
  logic          amm_read;
  logic [31:0]   amm_readdata;
  logic          amm_waitrequest;
  logic [NP-1:0] port_prsnt_n, port_rxlos, port_txdis, port_rs0, port_rs1, port_msel_n;
  logic          port_int_n, port_rst_n, i2c_busy, irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  port_sideband_ctrl #(.NPORTS(NP), .DEB_CYCLES(4), .GUARD_CYCLES(3), .RST_CYCLES(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .amm_address(amm_address), .amm_write(amm_write), .amm_writedata(amm_writedata),
    .amm_read(amm_read), .amm_readdata(amm_readdata), .amm_waitrequest(amm_waitrequest),
    .port_prsnt_n(port_prsnt_n), .port_rxlos(port_rxlos), .port_int_n(port_int_n),
    .port_txdis(port_txdis), .port_rs0(port_rs0), .port_rs1(port_rs1),
    .port_msel_n(port_msel_n), .port_rst_n(port_rst_n), .i2c_busy(i2c_busy), .irq(irq)
  );

  typedef struct {
    logic [9:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
    amm_address   = a;
    amm_writedata = d;
    amm_write     = 1'b1;
    tick();
    amm_write = 1'b0;
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
    amm_address = a;
    amm_read    = 1'b1;
    #1;
    check("waitrequest_first", {31'd0, amm_waitrequest}, 32'd1);
    tick();
    check("waitrequest_second", {31'd0, amm_waitrequest}, 32'd0);
    d        = amm_readdata;
    amm_read = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat, all_hi, lows;
    logic        ok, two_low;

    sys_rst = 1'b1; amm_address = '0; amm_write = 1'b0; amm_writedata = '0; amm_read = 1'b0;
    port_prsnt_n = '1; port_rxlos = '1; port_int_n = 1'b1; i2c_busy = 1'b0;
    repeat (3) tick();

    // reset values on pins
    check("rst_readdata", amm_readdata, 32'h0);
    check("rst_waitrequest", {31'd0, amm_waitrequest}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_txdis", {27'd0, port_txdis}, 32'h1F);
    check("rst_rs0", {27'd0, port_rs0}, 32'h0);
    check("rst_rs1", {27'd0, port_rs1}, 32'h0);
    check("rst_msel_n", {27'd0, port_msel_n}, 32'h1F);
    check("rst_port_rst_n", {31'd0, port_rst_n}, 32'h1);
    sys_rst = 1'b0;
    tick();

    // register map vectors
    vecs[0]  = '{10'd3,   1'b0, 32'h0,        32'h0000001F};
    vecs[1]  = '{10'd0,   1'b0, 32'h0,        32'h00001F00};
    vecs[2]  = '{10'd1,   1'b0, 32'h0,        32'h0};
    vecs[3]  = '{10'd2,   1'b0, 32'h0,        32'h0};
    vecs[4]  = '{10'd4,   1'b0, 32'h0,        32'h0};
    vecs[5]  = '{10'd5,   1'b0, 32'h0,        32'h0};
    vecs[6]  = '{10'd7,   1'b0, 32'h0,        32'h0};
    vecs[7]  = '{10'h103, 1'b0, 32'h0,        32'h0000001F};
    vecs[8]  = '{10'd3,   1'b1, 32'hFFFFFFFF, 32'h001F1F1F};
    vecs[9]  = '{10'd3,   1'b1, 32'h00150A15, 32'h00150A15};
    vecs[10] = '{10'd2,   1'b1, 32'hFFFFFFFF, 32'h00011F1F};
    vecs[11] = '{10'd2,   1'b1, 32'h00000004, 32'h00000004};
    vecs[12] = '{10'd6,   1'b1, 32'hFFFFFFFF, 32'h0};
    vecs[13] = '{10'd4,   1'b1, 32'h80000005, 32'h0};
    vecs[14] = '{10'd0,   1'b1, 32'hFFFFFFFF, 32'h00001F00};
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
    end
    check("ctrl_txdis_pins", {27'd0, port_txdis}, 32'h15);
    check("ctrl_rs0_pins", {27'd0, port_rs0}, 32'h0A);
    check("ctrl_rs1_pins", {27'd0, port_rs1}, 32'h15);
    check("msel_idx_oob_pins", {27'd0, port_msel_n}, 32'h1F);
    bus_write(10'd3, 32'h0000001F);

    // presence debounce latency and irq
    port_prsnt_n[2] = 1'b0;
    repeat (6) tick();
    check("irq_same_cycle_as_event", {31'd0, irq}, 32'h0);
    tick();
    check("irq_after_event", {31'd0, irq}, 32'h1);
    bus_read(10'd0, rd); check("status_prs2", rd, 32'h00001F04);
    bus_read(10'd1, rd); check("event_prs2", rd, 32'h4);

    // 3-cycle glitch is filtered
    port_rxlos[0] = 1'b0;
    repeat (3) tick();
    port_rxlos[0] = 1'b1;
    repeat (8) tick();
    bus_read(10'd0, rd); check("status_after_glitch", rd, 32'h00001F04);
    bus_read(10'd1, rd); check("event_after_glitch", rd, 32'h4);

    // W1C drops irq one cycle after the clear
    bus_write(10'd1, 32'h4);
    check("irq_at_w1c_edge", {31'd0, irq}, 32'h1);
    tick();
    check("irq_after_w1c", {31'd0, irq}, 32'h0);
    bus_read(10'd1, rd); check("event_cleared", rd, 32'h0);

    // int: rising edge only
    port_int_n = 1'b0;
    repeat (8) tick();
    bus_read(10'd1, rd); check("event_int_rise", rd, 32'h00010000);
    bus_read(10'd0, rd); check("status_int", rd, 32'h00011F04);
    check("irq_int_masked", {31'd0, irq}, 32'h0);
    bus_write(10'd1, 32'h00010000);
    port_int_n = 1'b1;
    repeat (8) tick();
    bus_read(10'd1, rd); check("event_int_fall_none", rd, 32'h0);

    // set and W1C in the same cycle: set wins
    port_prsnt_n[2] = 1'b1;
    repeat (5) tick();
    bus_write(10'd1, 32'h4);
    bus_read(10'd1, rd); check("event_set_beats_clear", rd, 32'h4);
    bus_read(10'd0, rd); check("status_prs2_gone", rd, 32'h00001F00);
    bus_write(10'd1, 32'h4);

    // module select held off by i2c_busy
    i2c_busy = 1'b1;
    bus_write(10'd4, 32'h80000003);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (port_msel_n !== 5'h1F) ok = 1'b0;
      tick();
    end
    check("msel_desel_while_busy", {31'd0, ok}, 32'h1);
    bus_read(10'd4, rd); check("msel_busy_flags", rd & 32'hC0000000, 32'h40000000);
    i2c_busy = 1'b0;
    lat = 0;
    while (port_msel_n === 5'h1F && lat < 20) begin
      tick();
      lat++;
    end
    check("grant_latency_after_busy", lat, 32'd4);
    check("msel_n_port3", {27'd0, port_msel_n}, 32'h17);
    bus_read(10'd4, rd); check("msel_read_granted3", rd, 32'h80000003);

    // retarget 3 -> 1 with guard gap
    bus_write(10'd4, 32'h80000001);
    check("msel3_released", {31'd0, port_msel_n[3]}, 32'h1);
    lat = 1; all_hi = 0; two_low = 1'b0;
    if (port_msel_n === 5'h1F) all_hi++;
    while (port_msel_n !== 5'h1D && lat < 20) begin
      if ($countones(~port_msel_n) > 1) two_low = 1'b1;
      tick();
      lat++;
      if (port_msel_n === 5'h1F) all_hi++;
    end
    check("reselect_latency", lat, 32'd5);
    check("reselect_gap_min3", {31'd0, all_hi >= 3}, 32'h1);
    check("never_two_low", {31'd0, two_low}, 32'h0);

    // out-of-range index while selected is ignored
    bus_write(10'd4, 32'h80000006);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (port_msel_n !== 5'h1D) ok = 1'b0;
      tick();
    end
    check("msel_oob_while_sel", {31'd0, ok}, 32'h1);

    // release
    bus_write(10'd4, 32'h00000001);
    check("release_desel", {27'd0, port_msel_n}, 32'h1F);
    tick();
    bus_read(10'd4, rd); check("release_flags", rd & 32'hC0000000, 32'h0);

    // reset pulse with retrigger
    bus_write(10'd5, 32'h1);
    lows = (port_rst_n == 1'b0) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (port_rst_n == 1'b0) lows++;
    end
    bus_write(10'd5, 32'h1);
    if (port_rst_n == 1'b0) lows++;
    for (int i = 0; i < 30 && port_rst_n == 1'b0; i++) begin
      tick();
      if (port_rst_n == 1'b0) lows++;
    end
    check("rst_pulse_len", lows, 32'd13);
    bus_read(10'd5, rd); check("reset_read_idle", rd, 32'h0);

    // sys_rst mid-operation
    bus_write(10'd3, 32'h00000A00);
    bus_write(10'd4, 32'h80000002);
    bus_write(10'd5, 32'h1);
    bus_read(10'd5, rd); check("reset_read_active", rd, 32'h1);
    check("rst_n_low_before_sysrst", {31'd0, port_rst_n}, 32'h0);
    sys_rst = 1'b1;
    tick();
    check("sysrst_rst_n", {31'd0, port_rst_n}, 32'h1);
    check("sysrst_msel_n", {27'd0, port_msel_n}, 32'h1F);
    check("sysrst_txdis", {27'd0, port_txdis}, 32'h1F);
    check("sysrst_rs0", {27'd0, port_rs0}, 32'h0);
    check("sysrst_readdata", amm_readdata, 32'h0);
    sys_rst = 1'b0;
    repeat (10) tick();
    check("post_sysrst_rst_n", {31'd0, port_rst_n}, 32'h1);
    check("post_sysrst_msel_n", {27'd0, port_msel_n}, 32'h1F);
    bus_read(10'd4, rd); check("post_sysrst_msel", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
